// File: rtl/qpu_pkg.sv
// Shared types for the QPU gate sequencer: opcodes, instruction record,
// sequencer FSM states and the issue-counter width.
package qpu_pkg;

  localparam int ISSUE_CNT_W = 16;
  localparam int QPU_REP_W   = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_X     = 2'b01,
    OP_H     = 2'b10,
    OP_RESET = 2'b11
  } qpu_op_t;

  // Default-width instruction record; the sequencer re-declares it with its
  // own REP_W so the FIFO carries exactly the bits in use.
  typedef struct packed {
    qpu_op_t                op;
    logic [QPU_REP_W-1:0]   rep;
  } qpu_instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

  // X and H are self-inverse rotations; an even run of either is identity.
  function automatic logic is_rotation(qpu_op_t op);
    return (op == OP_X) || (op == OP_H);
  endfunction

endpackage

// File: rtl/qpu_instr_fifo.sv
// Synchronous show-ahead FIFO of sequencer instructions.
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
module qpu_instr_fifo
  import qpu_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type instr_t = qpu_instr_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  instr_t                 data_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output instr_t                 head_o
);

  localparam int AW = $clog2(DEPTH);

  instr_t          mem_q [DEPTH];
  logic   [AW:0]   wr_q;
  logic   [AW:0]   rd_q;
  logic            do_push;
  logic            do_pop;

  // A blocked push or an underflowing pop leaves the state untouched.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/qpu_gate_sequencer.sv
// Upstream stage of the 1-qubit QPU core: buffers gate instructions and
// streams one 2-bit gate code per clock after start.
// Optional macro QSEQ_FUSE_EN: X/H runs collapse to parity (even -> one idle
// cycle, odd -> one issue).
module qpu_gate_sequencer
  import qpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int REP_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [REP_W-1:0]       in_rep,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             gate_out,
  output logic                   qpu_reset,
  output logic [ISSUE_CNT_W-1:0] issue_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    qpu_op_t          op;
    logic [REP_W-1:0] rep;
  } seq_instr_t;

  seq_instr_t             fifo_in;
  seq_instr_t             head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   push_acc;

  seq_state_t             state_q;
  logic [REP_W-1:0]       rep_q;
  logic                   fresh_q;
  logic [1:0]             gate_q;
  logic                   qrst_q;
  logic                   busy_q;
  logic                   done_q;
  logic [ISSUE_CNT_W-1:0] issue_q;

  logic                   step;
  logic                   pop;
  logic                   rep_last;
  logic                   is_rst;
  logic [1:0]             code;
  logic [REP_W-1:0]       eff_rep;
  logic [REP_W-1:0]       cur_rep;
  logic [REP_W-1:0]       rep_d;
  logic [ISSUE_CNT_W-1:0] issue_base;
  logic [ISSUE_CNT_W-1:0] issue_d;
  seq_state_t             run_next;

  assign fifo_in.op  = qpu_op_t'(in_op);
  assign fifo_in.rep = in_rep;
  assign in_ready    = !fifo_full;
  assign push_acc    = in_valid && in_ready;

  qpu_instr_fifo #(
    .DEPTH   (DEPTH),
    .instr_t (seq_instr_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_acc),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (head)
  );

  // Decode the head: code to issue, repeats still owed, and whether it retires now.
  always_comb begin
    is_rst  = (head.op == OP_RESET);
    code    = head.op;
    eff_rep = head.rep;
    if (is_rst) begin
      code    = 2'b00;
      eff_rep = '0;
    end
`ifdef QSEQ_FUSE_EN
    else if (is_rotation(head.op)) begin
      eff_rep = '0;
      if (head.rep[0]) code = 2'b00;
    end
`endif
    // A freshly exposed head starts from its own repeat field; otherwise
    // continue the countdown in progress.
    cur_rep    = fresh_q ? eff_rep : rep_q;
    rep_last   = (cur_rep == '0);
    rep_d      = rep_last ? '0 : cur_rep - REP_W'(1);
    step       = !fifo_empty && ((state_q == ST_RUN) || ((state_q == ST_IDLE) && start));
    pop        = step && rep_last;
    // Leaving the last entry with nothing arriving ends the program.
    run_next   = (pop && (fifo_count == CW'(1)) && !push_acc) ? ST_DONE : ST_RUN;
    issue_base = (state_q == ST_IDLE) ? '0 : issue_q;
    issue_d    = issue_base;
    if (((code == 2'b01) || (code == 2'b10)) && (issue_base != '1))
      issue_d = issue_base + ISSUE_CNT_W'(1);
  end

  // Sequencer FSM with registered gate/reset/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rep_q   <= '0;
      fresh_q <= 1'b1;
      gate_q  <= 2'b00;
      qrst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      issue_q <= '0;
    end else begin
      gate_q <= 2'b00;
      qrst_q <= 1'b0;
      done_q <= 1'b0;
      if (step) begin
        gate_q  <= code;
        qrst_q  <= is_rst;
        rep_q   <= rep_d;
        fresh_q <= rep_last;
        issue_q <= issue_d;
      end
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            if (fifo_empty) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= run_next;
            end
          end
        end
        ST_RUN: begin
          if (fifo_empty) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= run_next;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gate_out  = gate_q;
  assign qpu_reset = qrst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign issue_cnt = issue_q;

endmodule

// File: tb/tb_qpu_gate_sequencer.sv
// Directed bench for qpu_gate_sequencer; expectations follow QSEQ_FUSE_EN.
module tb_qpu_gate_sequencer;

  localparam int DEPTH = 8;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [1:0]       in_op = 2'b00;
  logic [REP_W-1:0] in_rep = '0;
  logic             start = 1'b0;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [1:0]       gate_out;
  logic             qpu_reset;
  logic [15:0]      issue_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_gate [$];
  logic       exp_qrst [$];

  always #5 clk = ~clk;

  qpu_gate_sequencer #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rep    (in_rep),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .gate_out  (gate_out),
    .qpu_reset (qpu_reset),
    .issue_cnt (issue_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [REP_W-1:0] rep);
    in_valid = 1'b1;
    in_op    = op;
    in_rep   = rep;
    tick();
    in_valid = 1'b0;
    $display("[TB] push op=%0d rep=%0d in_ready=%0b", op, rep, in_ready);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first cycle after start: walks the expected gate stream,
  // then checks the done pulse and the final issue count.
  task automatic check_stream(input string name, input int exp_issue);
    for (int i = 0; i < exp_gate.size(); i++) begin
      chk({name, "_gate"}, 32'(gate_out), 32'(exp_gate[i]));
      chk({name, "_qrst"}, 32'(qpu_reset), 32'(exp_qrst[i]));
      chk({name, "_busy"}, 32'(busy), 32'd1);
      tick();
      in_valid = 1'b0;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_gate_end"}, 32'(gate_out), 32'd0);
    chk({name, "_issue"}, 32'(issue_cnt), 32'(exp_issue));
    tick();
    chk({name, "_done_clr"}, 32'(done), 32'd0);
    $display("[TB] program %s: issue_cnt=%0d", name, issue_cnt);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_gate", 32'(gate_out), 32'd0);
    chk("rst_qrst", 32'(qpu_reset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_issue", 32'(issue_cnt), 32'd0);

    // Basic program {X,0},{H,2}
    push(2'b01, 4'd0);
    push(2'b10, 4'd2);
    pulse_start();
`ifdef QSEQ_FUSE_EN
    exp_gate = '{2'b01, 2'b10};
    exp_qrst = '{1'b0, 1'b0};
    check_stream("basic", 2);
`else
    exp_gate = '{2'b01, 2'b10, 2'b10, 2'b10};
    exp_qrst = '{1'b0, 1'b0, 1'b0, 1'b0};
    check_stream("basic", 4);
`endif

    // Fill to DEPTH, drop a 9th write, then push one more while running
    push(2'b01, 4'd0);
    push(2'b10, 4'd0);
    push(2'b00, 4'd0);
    push(2'b01, 4'd0);
    push(2'b10, 4'd0);
    push(2'b10, 4'd0);
    push(2'b00, 4'd0);
    push(2'b01, 4'd0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    push(2'b01, 4'd3);
    chk("full_drop_ready", 32'(in_ready), 32'd0);
    pulse_start();
    chk("pop_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_rep   = 4'd1;
`ifdef QSEQ_FUSE_EN
    exp_gate = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    exp_qrst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_stream("fill", 6);
`else
    exp_gate = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10};
    exp_qrst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_stream("fill", 8);
`endif

    // RESET instruction then {X,1}
    push(2'b11, 4'd3);
    push(2'b01, 4'd1);
    pulse_start();
`ifdef QSEQ_FUSE_EN
    exp_gate = '{2'b00, 2'b00};
    exp_qrst = '{1'b1, 1'b0};
    check_stream("qreset", 0);
`else
    exp_gate = '{2'b00, 2'b01, 2'b01};
    exp_qrst = '{1'b1, 1'b0, 1'b0};
    check_stream("qreset", 2);
`endif

    // Start on an empty FIFO
    pulse_start();
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_gate", 32'(gate_out), 32'd0);
    tick();
    chk("empty_done_clr", 32'(done), 32'd0);
    chk("empty_busy2", 32'(busy), 32'd0);
    $display("[TB] empty start checked");

    // Reset during the second cycle of {H,5}
    push(2'b10, 4'd5);
    pulse_start();
`ifndef QSEQ_FUSE_EN
    chk("abort_first_gate", 32'(gate_out), 32'd2);
`endif
    tick();
    reset = 1'b1;
    tick();
    chk("abort_gate", 32'(gate_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_issue", 32'(issue_cnt), 32'd0);
    chk("abort_qrst", 32'(qpu_reset), 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    pulse_start();
    chk("abort_fifo_empty_done", 32'(done), 32'd1);
    chk("abort_fifo_empty_busy", 32'(busy), 32'd0);
    tick();
    $display("[TB] mid-run reset checked");

    // Fusion program {X,1},{H,2}
    push(2'b01, 4'd1);
    push(2'b10, 4'd2);
    pulse_start();
`ifdef QSEQ_FUSE_EN
    exp_gate = '{2'b00, 2'b10};
    exp_qrst = '{1'b0, 1'b0};
    check_stream("fuse", 1);
`else
    exp_gate = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    exp_qrst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_stream("fuse", 5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
